// File: rtl/crc32_multi_hash_pkg.sv
// Shared constants, FSM state type and bit-reflection helpers for the multi-row CRC32 hash engine.
// The optional reflected (zlib-compatible) mode is enabled by defining CRC_HASH_REFLECT_EN.
package crc_hash_pkg;

   localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
   localparam int          BEAT_W   = 64;

   // One seed per sketch row; row 0 uses the standard CRC-32 initial value.
   localparam logic [31:0] HASH_SEED [0:7] = '{
      32'hFFFFFFFF, 32'h1B873593, 32'hCC9E2D51, 32'h85EBCA6B,
      32'hC2B2AE35, 32'h27D4EB2F, 32'h165667B1, 32'h9E3779B9
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } hash_state_t;

   function automatic logic [63:0] byte_reflect(input logic [63:0] data);
      logic [63:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < 8; i++) begin
            r[8*b + i] = data[8*b + 7 - i];
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] reflect32(input logic [31:0] value);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = value[31 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_d64_step.sv
// Combinational CRC32 update over one 64-bit beat; bytes are consumed lowest first,
// and each byte is shifted in MSB first.
module crc32_d64_step
   import crc_hash_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [63:0] data,
   output logic [31:0] crc_out
);

   logic [31:0] crc_acc;

   always_comb begin
      crc_acc = crc_in;
      for (int b = 0; b < 8; b++) begin
         for (int i = 7; i >= 0; i--) begin
            if (crc_acc[31] ^ data[8*b + i]) begin
               crc_acc = {crc_acc[30:0], 1'b0} ^ CRC_POLY;
            end else begin
               crc_acc = {crc_acc[30:0], 1'b0};
            end
         end
      end
      crc_out = crc_acc;
   end

endmodule

// File: rtl/crc32_multi_hash.sv
// Multi-row CRC32 hash engine: NUM_HASH seeded CRC lanes over a KEY_W key, one beat per cycle.
// Define CRC_HASH_REFLECT_EN for byte-reflected input and reflected, inverted (zlib-style) output.
module crc32_multi_hash
   import crc_hash_pkg::*;
#(
   parameter int KEY_W    = 64,
   parameter int NUM_HASH = 3,
   parameter int IDX_W    = 16
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [KEY_W-1:0]          key,
   input  logic                      key_valid,
   output logic                      key_ready,
   output logic [NUM_HASH*32-1:0]    hash_out,
   output logic [NUM_HASH*IDX_W-1:0] hash_idx,
   output logic                      hash_valid,
   input  logic                      hash_ready
);

   localparam int BEATS = KEY_W / BEAT_W;
   localparam int CNT_W = 4;

   hash_state_t          state;
   hash_state_t          state_next;
   logic [KEY_W-1:0]     key_sr;
   logic [CNT_W-1:0]     beat_cnt;
   logic [31:0]          crc_q    [NUM_HASH];
   logic [31:0]          crc_next [NUM_HASH];
   logic [NUM_HASH*32-1:0] hash_q;
   logic [BEAT_W-1:0]    step_data;
   logic                 accept;
   logic                 last_beat;

   function automatic logic [31:0] finalize(input logic [31:0] crc);
`ifdef CRC_HASH_REFLECT_EN
      return reflect32(crc) ^ 32'hFFFFFFFF;
`else
      return crc;
`endif
   endfunction

`ifdef CRC_HASH_REFLECT_EN
   assign step_data = byte_reflect(key_sr[BEAT_W-1:0]);
`else
   assign step_data = key_sr[BEAT_W-1:0];
`endif

   assign accept    = key_valid && key_ready;
   assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

   // Every lane sees the same beat; only the starting seed differs.
   for (genvar g = 0; g < NUM_HASH; g++) begin : g_lane
      crc32_d64_step u_step (
         .crc_in  (crc_q[g]),
         .data    (step_data),
         .crc_out (crc_next[g])
      );
      assign hash_idx[g*IDX_W +: IDX_W] = hash_q[g*32 +: IDX_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // key_ready looks at hash_ready directly so a result can be retired and a new key taken in one cycle.
   always_comb begin
      state_next = state;
      key_ready  = 1'b0;
      hash_valid = 1'b0;
      case (state)
         IDLE: begin
            key_ready = !reset;
            if (key_valid) begin
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (last_beat) begin
               state_next = OUT;
            end
         end
         OUT: begin
            hash_valid = 1'b1;
            key_ready  = !reset && hash_ready;
            if (hash_ready) begin
               state_next = key_valid ? ACCUM : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Results are only written on the last beat, so a reset mid-key never exposes a partial hash.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_sr   <= '0;
         beat_cnt <= '0;
         hash_q   <= '0;
         for (int i = 0; i < NUM_HASH; i++) begin
            crc_q[i] <= '0;
         end
      end else if (accept) begin
         key_sr   <= key;
         beat_cnt <= '0;
         for (int i = 0; i < NUM_HASH; i++) begin
            crc_q[i] <= HASH_SEED[i];
         end
      end else if (state == ACCUM) begin
         key_sr   <= key_sr >> BEAT_W;
         beat_cnt <= beat_cnt + 1'b1;
         for (int i = 0; i < NUM_HASH; i++) begin
            crc_q[i] <= crc_next[i];
         end
         if (last_beat) begin
            for (int i = 0; i < NUM_HASH; i++) begin
               hash_q[32*i +: 32] <= finalize(crc_next[i]);
            end
         end
      end
   end

   assign hash_out = hash_q;

endmodule

// File: tb/tb_crc32_multi_hash.sv
// Self-checking bench for crc32_multi_hash: two instances (256-bit/3-lane and 64-bit/1-lane)
// checked against a table-driven software CRC model; honours CRC_HASH_REFLECT_EN.
module tb_crc32_multi_hash;

   localparam int A_KEY_W = 256;
   localparam int A_NUM   = 3;
   localparam int A_IDX   = 16;
   localparam int A_BEATS = 4;
   localparam int B_KEY_W = 64;
   localparam int B_NUM   = 1;
   localparam int B_IDX   = 16;

   localparam logic [31:0] SEEDS [0:7] = '{
      32'hFFFFFFFF, 32'h1B873593, 32'hCC9E2D51, 32'h85EBCA6B,
      32'hC2B2AE35, 32'h27D4EB2F, 32'h165667B1, 32'h9E3779B9
   };

   logic clk = 1'b0;
   logic reset;

   logic [A_KEY_W-1:0]     a_key;
   logic                   a_key_valid;
   logic                   a_key_ready;
   logic [A_NUM*32-1:0]    a_hash_out;
   logic [A_NUM*A_IDX-1:0] a_hash_idx;
   logic                   a_hash_valid;
   logic                   a_hash_ready;

   logic [B_KEY_W-1:0]     b_key;
   logic                   b_key_valid;
   logic                   b_key_ready;
   logic [B_NUM*32-1:0]    b_hash_out;
   logic [B_NUM*B_IDX-1:0] b_hash_idx;
   logic                   b_hash_valid;
   logic                   b_hash_ready;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   crc32_multi_hash #(.KEY_W(A_KEY_W), .NUM_HASH(A_NUM), .IDX_W(A_IDX)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .key        (a_key),
      .key_valid  (a_key_valid),
      .key_ready  (a_key_ready),
      .hash_out   (a_hash_out),
      .hash_idx   (a_hash_idx),
      .hash_valid (a_hash_valid),
      .hash_ready (a_hash_ready)
   );

   crc32_multi_hash #(.KEY_W(B_KEY_W), .NUM_HASH(B_NUM), .IDX_W(B_IDX)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .key        (b_key),
      .key_valid  (b_key_valid),
      .key_ready  (b_key_ready),
      .hash_out   (b_hash_out),
      .hash_idx   (b_hash_idx),
      .hash_valid (b_hash_valid),
      .hash_ready (b_hash_ready)
   );

   // Byte-at-a-time table CRC, the classic software formulation.
   function automatic logic [31:0] bit_rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31 - i];
      return r;
   endfunction

   function automatic logic [31:0] table_msb(input logic [7:0] idx);
      logic [31:0] c;
      c = {idx, 24'h0};
      for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      return c;
   endfunction

   function automatic logic [31:0] table_lsb(input logic [7:0] idx);
      logic [31:0] c;
      c = {24'h0, idx};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   function automatic logic [31:0] ref_crc(input logic [31:0] seed, input logic [511:0] k, input int nbytes);
      logic [31:0] c;
      logic [7:0]  b;
`ifdef CRC_HASH_REFLECT_EN
      c = bit_rev32(seed);
      for (int n = 0; n < nbytes; n++) begin
         b = k[8*n +: 8];
         c = (c >> 8) ^ table_lsb(c[7:0] ^ b);
      end
      return c ^ 32'hFFFFFFFF;
`else
      c = seed;
      for (int n = 0; n < nbytes; n++) begin
         b = k[8*n +: 8];
         c = (c << 8) ^ table_msb(c[31:24] ^ b);
      end
      return c;
`endif
   endfunction

   function automatic logic [A_NUM*32-1:0] exp_vec_a(input logic [A_KEY_W-1:0] k);
      logic [A_NUM*32-1:0] v;
      for (int i = 0; i < A_NUM; i++) v[32*i +: 32] = ref_crc(SEEDS[i], {256'b0, k}, A_KEY_W / 8);
      return v;
   endfunction

   function automatic logic [A_KEY_W-1:0] rand_key();
      logic [A_KEY_W-1:0] r;
      for (int i = 0; i < A_KEY_W / 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid_a(output int lat);
      lat = 0;
      while (!a_hash_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks += 6;
      if (a_key_ready !== 1'b0) $display("[TB] FAIL reset_a_key_ready got=%b want=0", a_key_ready); else passes++;
      if (a_hash_valid !== 1'b0) $display("[TB] FAIL reset_a_hash_valid got=%b want=0", a_hash_valid); else passes++;
      if (a_hash_out !== '0) $display("[TB] FAIL reset_a_hash_out got=%h want=0", a_hash_out); else passes++;
      if (a_hash_idx !== '0) $display("[TB] FAIL reset_a_hash_idx got=%h want=0", a_hash_idx); else passes++;
      if (b_key_ready !== 1'b0) $display("[TB] FAIL reset_b_key_ready got=%b want=0", b_key_ready); else passes++;
      if (b_hash_out !== '0) $display("[TB] FAIL reset_b_hash_out got=%h want=0", b_hash_out); else passes++;
      reset = 1'b0;
      tick();
      checks += 3;
      if (a_key_ready !== 1'b1) $display("[TB] FAIL post_reset_a_key_ready got=%b want=1", a_key_ready); else passes++;
      if (b_key_ready !== 1'b1) $display("[TB] FAIL post_reset_b_key_ready got=%b want=1", b_key_ready); else passes++;
      if (a_hash_valid !== 1'b0) $display("[TB] FAIL post_reset_a_hash_valid got=%b want=0", a_hash_valid); else passes++;
   endtask

   task automatic test_zero_key();
      logic [31:0] exp;
      exp = ref_crc(SEEDS[0], 512'b0, 8);
      b_key        = '0;
      b_key_valid  = 1'b1;
      b_hash_ready = 1'b1;
      #1;
      checks++;
      if (b_key_ready !== 1'b1) $display("[TB] FAIL zero_key_ready got=%b want=1", b_key_ready); else passes++;
      tick();
      b_key_valid = 1'b0;
      b_key       = 64'hDEAD_BEEF_0123_4567;
      checks++;
      if (b_hash_valid !== 1'b0) $display("[TB] FAIL zero_valid_t1 got=%b want=0", b_hash_valid); else passes++;
      tick();
      checks += 3;
      if (b_hash_valid !== 1'b1) $display("[TB] FAIL zero_valid_t2 got=%b want=1", b_hash_valid); else passes++;
      if (b_hash_out !== exp) $display("[TB] FAIL zero_hash_out got=%h want=%h", b_hash_out, exp); else passes++;
      if (b_hash_idx !== exp[15:0]) $display("[TB] FAIL zero_hash_idx got=%h want=%h", b_hash_idx, exp[15:0]); else passes++;
      checks++;
`ifdef CRC_HASH_REFLECT_EN
      if (b_hash_out !== 32'h6522DF69) $display("[TB] FAIL zero_zlib got=%h want=6522df69", b_hash_out); else passes++;
`else
      if (b_hash_out === 32'h6522DF69) $display("[TB] FAIL zero_raw_mode got=%h want anything but 6522df69", b_hash_out); else passes++;
`endif
      tick();
      checks += 2;
      if (b_hash_valid !== 1'b0) $display("[TB] FAIL zero_drain_valid got=%b want=0", b_hash_valid); else passes++;
      if (b_key_ready !== 1'b1) $display("[TB] FAIL zero_drain_ready got=%b want=1", b_key_ready); else passes++;
   endtask

   task automatic test_random_keys();
      logic [A_KEY_W-1:0]   k;
      logic [A_NUM*32-1:0]  exp;
      int lat;
      for (int n = 0; n < 4; n++) begin
         k   = rand_key();
         exp = exp_vec_a(k);
         a_key        = k;
         a_key_valid  = 1'b1;
         a_hash_ready = 1'b1;
         #1;
         checks++;
         if (a_key_ready !== 1'b1) $display("[TB] FAIL rand_key_ready[%0d] got=%b want=1", n, a_key_ready); else passes++;
         tick();
         a_key_valid = 1'b0;
         a_key       = rand_key();
         wait_valid_a(lat);
         checks++;
         if (lat !== A_BEATS) $display("[TB] FAIL rand_latency[%0d] got=%0d want=%0d", n, lat, A_BEATS); else passes++;
         for (int i = 0; i < A_NUM; i++) begin
            checks += 2;
            if (a_hash_out[32*i +: 32] !== exp[32*i +: 32])
               $display("[TB] FAIL rand_lane%0d[%0d] got=%h want=%h", i, n, a_hash_out[32*i +: 32], exp[32*i +: 32]);
            else passes++;
            if (a_hash_idx[16*i +: 16] !== exp[32*i +: 16])
               $display("[TB] FAIL rand_idx%0d[%0d] got=%h want=%h", i, n, a_hash_idx[16*i +: 16], exp[32*i +: 16]);
            else passes++;
         end
         for (int i = 1; i < A_NUM; i++) begin
            checks++;
            if (a_hash_out[32*i +: 32] === exp[31:0])
               $display("[TB] FAIL rand_lane_distinct%0d[%0d] got=%h want!=%h", i, n, a_hash_out[32*i +: 32], exp[31:0]);
            else passes++;
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [A_KEY_W-1:0]  k1;
      logic [A_KEY_W-1:0]  k2;
      logic [A_NUM*32-1:0] exp1;
      logic [A_NUM*32-1:0] exp2;
      int lat;
      k1 = rand_key();
      k2 = rand_key();
      exp1 = exp_vec_a(k1);
      exp2 = exp_vec_a(k2);
      a_hash_ready = 1'b0;
      a_key        = k1;
      a_key_valid  = 1'b1;
      tick();
      a_key_valid = 1'b0;
      wait_valid_a(lat);
      checks++;
      if (lat !== A_BEATS) $display("[TB] FAIL bp_latency1 got=%0d want=%0d", lat, A_BEATS); else passes++;
      a_key_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         a_key = rand_key();
         #1;
         checks += 3;
         if (a_hash_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid[%0d] got=%b want=1", c, a_hash_valid); else passes++;
         if (a_key_ready !== 1'b0) $display("[TB] FAIL bp_hold_ready[%0d] got=%b want=0", c, a_key_ready); else passes++;
         if (a_hash_out !== exp1) $display("[TB] FAIL bp_hold_out[%0d] got=%h want=%h", c, a_hash_out, exp1); else passes++;
         tick();
      end
      a_key        = k2;
      a_hash_ready = 1'b1;
      #1;
      checks++;
      if (a_key_ready !== 1'b1) $display("[TB] FAIL bp_release_ready got=%b want=1", a_key_ready); else passes++;
      tick();
      a_key_valid = 1'b0;
      a_key       = rand_key();
      wait_valid_a(lat);
      checks += 2;
      if (lat !== A_BEATS) $display("[TB] FAIL bp_latency2 got=%0d want=%0d", lat, A_BEATS); else passes++;
      if (a_hash_out !== exp2) $display("[TB] FAIL bp_second_out got=%h want=%h", a_hash_out, exp2); else passes++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [A_NUM*32-1:0] expq[$];
      logic [A_NUM*32-1:0] exp;
      logic [A_KEY_W-1:0]  kcur;
      logic accepted;
      int sent = 0;
      int got = 0;
      int cyc = 0;
      int last_cyc = -1;
      a_hash_ready = 1'b1;
      kcur        = rand_key();
      a_key       = kcur;
      a_key_valid = 1'b1;
      while (got < 20 && cyc < 300) begin
         #1;
         if (a_hash_valid) begin
            checks++;
            if (expq.size() == 0) begin
               $display("[TB] FAIL b2b_unexpected_result[%0d] got=%h want=none", got, a_hash_out);
            end else begin
               exp = expq.pop_front();
               if (a_hash_out !== exp) $display("[TB] FAIL b2b_out[%0d] got=%h want=%h", got, a_hash_out, exp); else passes++;
            end
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc !== A_BEATS + 1)
                  $display("[TB] FAIL b2b_gap[%0d] got=%0d want=%0d", got, cyc - last_cyc, A_BEATS + 1);
               else passes++;
            end
            last_cyc = cyc;
            got++;
         end
         accepted = a_key_valid && a_key_ready;
         if (accepted) begin
            expq.push_back(exp_vec_a(kcur));
            sent++;
         end
         tick();
         cyc++;
         if (accepted) begin
            if (sent == 20) begin
               a_key_valid = 1'b0;
            end else begin
               kcur  = rand_key();
               a_key = kcur;
            end
         end
      end
      checks += 2;
      if (got !== 20) $display("[TB] FAIL b2b_count got=%0d want=20", got); else passes++;
      if (expq.size() !== 0) $display("[TB] FAIL b2b_leftover got=%0d want=0", expq.size()); else passes++;
      a_key_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_accum();
      logic [A_KEY_W-1:0]  k;
      logic [A_NUM*32-1:0] exp;
      logic seen_valid;
      int lat;
      a_hash_ready = 1'b1;
      a_key        = rand_key();
      a_key_valid  = 1'b1;
      tick();
      a_key_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (a_key_ready !== 1'b0) $display("[TB] FAIL mid_reset_ready got=%b want=0", a_key_ready); else passes++;
      tick();
      reset = 1'b0;
      #1;
      checks += 2;
      if (a_key_ready !== 1'b1) $display("[TB] FAIL mid_after_ready got=%b want=1", a_key_ready); else passes++;
      if (a_hash_valid !== 1'b0) $display("[TB] FAIL mid_after_valid got=%b want=0", a_hash_valid); else passes++;
      seen_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (a_hash_valid) seen_valid = 1'b1;
         tick();
      end
      checks++;
      if (seen_valid !== 1'b0) $display("[TB] FAIL mid_no_partial got=%b want=0", seen_valid); else passes++;
      k   = rand_key();
      exp = exp_vec_a(k);
      a_key       = k;
      a_key_valid = 1'b1;
      tick();
      a_key_valid = 1'b0;
      wait_valid_a(lat);
      checks += 2;
      if (lat !== A_BEATS) $display("[TB] FAIL mid_next_latency got=%0d want=%0d", lat, A_BEATS); else passes++;
      if (a_hash_out !== exp) $display("[TB] FAIL mid_next_out got=%h want=%h", a_hash_out, exp); else passes++;
      tick();
   endtask

   initial begin
      reset        = 1'b1;
      a_key        = '0;
      a_key_valid  = 1'b0;
      a_hash_ready = 1'b0;
      b_key        = '0;
      b_key_valid  = 1'b0;
      b_hash_ready = 1'b0;
      test_reset();
      test_zero_key();
      test_random_keys();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_accum();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
